// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic-unit command sequencer.
//   DATA_W            : datapath width of the arithmetic unit
//   op_t / OP_*       : command op encoding (ADD, SUB, PASSB, NEGB)
//   state_t           : sequencer states (IDLE, EXEC, DONE)
//   op_to_sel()       : maps an op to the unit's {S2, S3} select pair
package arith_pkg;

  localparam int DATA_W = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD   = 2'b00;
  localparam op_t OP_SUB   = 2'b01;
  localparam op_t OP_PASSB = 2'b10;
  localparam op_t OP_NEGB  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {s2, s3}. S2 forces the A input to zero, S3 selects ~B with
  // carry-in so the unit subtracts.
  function automatic logic [1:0] op_to_sel(input op_t op);
    logic [1:0] sel;
    case (op)
      OP_ADD:   sel = 2'b00;
      OP_SUB:   sel = 2'b01;
      OP_PASSB: sel = 2'b10;
      default:  sel = 2'b11;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/arith_flag_calc.sv
// Combinational status-flag generator for the arithmetic unit result.
//   i_op   : operation that produced the sum
//   i_a    : registered operand A (as presented to the unit)
//   i_b    : registered operand B (as presented to the unit)
//   i_sum  : sum returned by the unit
//   o_z    : result is zero
//   o_n    : result sign bit
//   o_v    : signed overflow for the operation
module arith_flag_calc
  import arith_pkg::*;
(
  input  op_t               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_sum,
  output logic              o_z,
  output logic              o_n,
  output logic              o_v
);

  localparam int MSB = DATA_W - 1;

  // Most negative value; negating it is the only NEGB overflow case.
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    o_z = (i_sum == '0);
    o_n = i_sum[MSB];
    case (i_op)
      OP_ADD:   o_v = (i_a[MSB] == i_b[MSB]) && (i_sum[MSB] != i_a[MSB]);
      OP_SUB:   o_v = (i_a[MSB] != i_b[MSB]) && (i_sum[MSB] != i_a[MSB]);
      OP_PASSB: o_v = 1'b0;
      default:  o_v = (i_b == MOST_NEG);
    endcase
  end

endmodule

// File: rtl/arith_op_sequencer.sv
// Command-side controller wrapped around the 4-bit arithmetic unit.
// One operation is accepted per cmd handshake, executed on the external
// combinational unit for exactly one cycle, and presented on the res
// handshake with flags. A 4-bit accumulator holds the last result so a
// command can substitute it for operand A; op_count counts completions.
//   CLK, RST            : clock, synchronous active-high reset
//   cmd_valid/ready     : command handshake
//   cmd_op/a/b/use_acc  : operation, operands, accumulator substitution
//   au_a/b/s2/s3        : registered drive to the arithmetic unit
//   au_s, au_c_out      : sum and carry returned by the unit
//   res_valid/ready     : result handshake
//   res_data/c/z/n/v    : captured sum, raw carry and flags
//   acc_out, op_count   : accumulator and completed-operation counter
module arith_op_sequencer
  import arith_pkg::*;
#(
  parameter logic [DATA_W-1:0] ACC_INIT = 4'h0,
  parameter int                COUNT_W  = 8
)
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [DATA_W-1:0]  cmd_a,
  input  logic [DATA_W-1:0]  cmd_b,
  input  logic               cmd_use_acc,
  output logic [DATA_W-1:0]  au_a,
  output logic [DATA_W-1:0]  au_b,
  output logic               au_s2,
  output logic               au_s3,
  input  logic [DATA_W-1:0]  au_s,
  input  logic               au_c_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_c,
  output logic               res_z,
  output logic               res_n,
  output logic               res_v,
  output logic [DATA_W-1:0]  acc_out,
  output logic [COUNT_W-1:0] op_count
);

  state_t              r_state;
  state_t              w_next;
  op_t                 r_op;
  logic [DATA_W-1:0]   r_au_a;
  logic [DATA_W-1:0]   r_au_b;
  logic                r_au_s2;
  logic                r_au_s3;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_res_c;
  logic                r_res_z;
  logic                r_res_n;
  logic                r_res_v;
  logic [DATA_W-1:0]   r_acc;
  logic [COUNT_W-1:0]  r_op_count;

  logic                w_accept;
  logic                w_capture;
  logic [1:0]          w_sel;
  logic                w_z;
  logic                w_n;
  logic                w_v;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = EXEC;
      EXEC:    w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs, decoded from state only
  always_comb begin
    cmd_ready = (r_state == IDLE);
    res_valid = (r_state == DONE);
  end

  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_capture = (r_state == EXEC);
  assign w_sel     = op_to_sel(op_t'(cmd_op));

  // Flags are formed from the operands held on the unit inputs and the
  // sum being captured, so they are registered together with res_data.
  arith_flag_calc u_flags (
    .i_op  (r_op),
    .i_a   (r_au_a),
    .i_b   (r_au_b),
    .i_sum (au_s),
    .o_z   (w_z),
    .o_n   (w_n),
    .o_v   (w_v)
  );

  // Accept stage: operands and selects go straight onto the unit inputs.
  // Capture stage (end of EXEC): result, flags, accumulator and counter.
  // A reset on the capture edge wins, so an in-flight op leaves no trace.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op       <= OP_ADD;
      r_au_a     <= '0;
      r_au_b     <= '0;
      r_au_s2    <= 1'b0;
      r_au_s3    <= 1'b0;
      r_res_data <= '0;
      r_res_c    <= 1'b0;
      r_res_z    <= 1'b0;
      r_res_n    <= 1'b0;
      r_res_v    <= 1'b0;
      r_acc      <= ACC_INIT;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= op_t'(cmd_op);
        r_au_a  <= cmd_use_acc ? r_acc : cmd_a;
        r_au_b  <= cmd_b;
        r_au_s2 <= w_sel[1];
        r_au_s3 <= w_sel[0];
      end
      if (w_capture) begin
        r_res_data <= au_s;
        r_res_c    <= au_c_out;
        r_res_z    <= w_z;
        r_res_n    <= w_n;
        r_res_v    <= w_v;
        r_acc      <= au_s;
        r_op_count <= r_op_count + COUNT_W'(1);
      end
    end
  end

  assign au_a     = r_au_a;
  assign au_b     = r_au_b;
  assign au_s2    = r_au_s2;
  assign au_s3    = r_au_s3;
  assign res_data = r_res_data;
  assign res_c    = r_res_c;
  assign res_z    = r_res_z;
  assign res_n    = r_res_n;
  assign res_v    = r_res_v;
  assign acc_out  = r_acc;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_arith_op_sequencer.sv
module tb_arith_op_sequencer;

  localparam logic [1:0] T_ADD   = 2'b00;
  localparam logic [1:0] T_SUB   = 2'b01;
  localparam logic [1:0] T_PASSB = 2'b10;
  localparam logic [1:0] T_NEGB  = 2'b11;
  localparam logic [3:0] INIT    = 4'h3;

  typedef struct packed {
    logic [3:0] d;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } res_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_a = 4'h0;
  logic [3:0] cmd_b = 4'h0;
  logic       cmd_use_acc = 1'b0;
  logic [3:0] au_a;
  logic [3:0] au_b;
  logic       au_s2;
  logic       au_s3;
  logic [3:0] au_s;
  logic       au_c_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_c;
  logic       res_z;
  logic       res_n;
  logic       res_v;
  logic [3:0] acc_out;
  logic [7:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected observable state
  logic       chk_en = 1'b0;
  logic       m_rdy  = 1'b1;
  logic       m_rv   = 1'b0;
  logic [3:0] m_acc  = INIT;
  logic [7:0] m_cnt  = 8'd0;
  res_t       m_res  = '0;

  always #5 CLK = ~CLK;

  arith_op_sequencer #(.ACC_INIT(INIT), .COUNT_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .au_a        (au_a),
    .au_b        (au_b),
    .au_s2       (au_s2),
    .au_s3       (au_s3),
    .au_s        (au_s),
    .au_c_out    (au_c_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_c       (res_c),
    .res_z       (res_z),
    .res_n       (res_n),
    .res_v       (res_v),
    .acc_out     (acc_out),
    .op_count    (op_count)
  );

  // Arithmetic unit: A (or 0) plus B (or ~B with carry-in)
  logic [4:0] w_unit;
  assign w_unit   = {1'b0, (au_s2 ? 4'h0 : au_a)} + {1'b0, (au_s3 ? ~au_b : au_b)} + {4'b0, au_s3};
  assign au_s     = w_unit[3:0];
  assign au_c_out = w_unit[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an operation from integer arithmetic on the operand values
  function automatic res_t model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, u, s;
    res_t r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    r = '0;
    case (op)
      T_ADD:   begin u = ua + ub; s = sa + sb; r.c = (u > 15); end
      T_SUB:   begin u = ua - ub; s = sa - sb; r.c = (ua >= ub); end
      T_PASSB: begin u = ub;      s = sb;      r.c = 1'b0; end
      default: begin u = -ub;     s = -sb;     r.c = (ub == 0); end
    endcase
    r.d = 4'(u);
    r.v = (s > 7) || (s < -8);
    r.z = (r.d == 4'h0);
    r.n = r.d[3];
    return r;
  endfunction

  // Per-cycle comparison against the expected state
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(m_rdy));
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("acc_out",   32'(acc_out),   32'(m_acc));
      chk("op_count",  32'(op_count),  32'(m_cnt));
      if (m_rv) begin
        chk("res_data", 32'(res_data), 32'(m_res.d));
        chk("res_c",    32'(res_c),    32'(m_res.c));
        chk("res_z",    32'(res_z),    32'(m_res.z));
        chk("res_n",    32'(res_n),    32'(m_res.n));
        chk("res_v",    32'(res_v),    32'(m_res.v));
      end
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    m_acc = INIT; m_cnt = 8'd0; m_rdy = 1'b1; m_rv = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic use_acc, input int stall, input logic hold_valid);
    logic [3:0] ae;
    res_t e;
    ae = use_acc ? m_acc : a;
    e  = model(op, ae, b);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    @(posedge CLK);
    #1;
    m_rdy = 1'b0;
    @(negedge CLK);
    cmd_valid = hold_valid;
    cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
    chk("exec_au_a",  32'(au_a),  32'(ae));
    chk("exec_au_b",  32'(au_b),  32'(b));
    chk("exec_au_s2", 32'(au_s2), 32'(op == T_PASSB || op == T_NEGB));
    chk("exec_au_s3", 32'(au_s3), 32'(op == T_SUB || op == T_NEGB));
    @(posedge CLK);
    #1;
    m_res = e; m_acc = e.d; m_cnt = m_cnt + 8'd1; m_rv = 1'b1;
    repeat (stall) @(posedge CLK);
    @(negedge CLK);
    res_ready = 1'b1;
    @(posedge CLK);
    #1;
    res_ready = 1'b0;
    m_rv = 1'b0; m_rdy = 1'b1;
  endtask

  logic [1:0] tv_op [4] = '{T_SUB, T_ADD, T_NEGB, T_PASSB};
  logic [3:0] tv_a  [4] = '{4'h8, 4'h8, 4'h5, 4'h2};
  logic [3:0] tv_b  [4] = '{4'h1, 4'h8, 4'h0, 4'hF};

  initial begin
    logic [7:0] iv;
    // Reset and idle
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_acc",       32'(acc_out),   32'h3);
    chk("rst_count",     32'(op_count),  32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_au_a",      32'(au_a),      32'd0);
    chk("rst_au_s3",     32'(au_s3),     32'd0);
    chk_en = 1'b1;

    // Reset during EXEC of ADD 1+1 discards the op
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = T_ADD; cmd_a = 4'h1; cmd_b = 4'h1; cmd_use_acc = 1'b0;
    @(posedge CLK);
    #1;
    m_rdy = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    m_rdy = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rexec_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rexec_count", 32'(op_count), 32'd0);
    chk("rexec_acc",   32'(acc_out),  32'h3);

    // ADD 7+3
    do_op(T_ADD, 4'h7, 4'h3, 1'b0, 0, 1'b0);
    chk("add_data", 32'(res_data), 32'hA);
    chk("add_c",    32'(res_c),    32'd0);
    chk("add_z",    32'(res_z),    32'd0);
    chk("add_n",    32'(res_n),    32'd1);
    chk("add_v",    32'(res_v),    32'd1);

    // SUB 5-5 then NEGB 8
    do_op(T_SUB, 4'h5, 4'h5, 1'b0, 0, 1'b0);
    chk("sub_data", 32'(res_data), 32'h0);
    chk("sub_c",    32'(res_c),    32'd1);
    chk("sub_z",    32'(res_z),    32'd1);
    chk("sub_v",    32'(res_v),    32'd0);
    do_op(T_NEGB, 4'h0, 4'h8, 1'b0, 0, 1'b0);
    chk("negb_data", 32'(res_data), 32'h8);
    chk("negb_c",    32'(res_c),    32'd0);
    chk("negb_n",    32'(res_n),    32'd1);
    chk("negb_v",    32'(res_v),    32'd1);

    // Accumulator chain from a fresh reset
    apply_reset();
    do_op(T_PASSB, 4'h0, 4'h4, 1'b0, 0, 1'b0);
    chk("chain_acc1", 32'(acc_out), 32'h4);
    do_op(T_ADD, 4'hF, 4'h9, 1'b1, 0, 1'b0);
    chk("chain_data",  32'(res_data), 32'hD);
    chk("chain_c",     32'(res_c),    32'd0);
    chk("chain_n",     32'(res_n),    32'd1);
    chk("chain_v",     32'(res_v),    32'd0);
    chk("chain_acc",   32'(acc_out),  32'hD);
    chk("chain_count", 32'(op_count), 32'd2);

    // Output stall with cmd_valid held high, then a following command
    do_op(T_SUB, 4'h3, 4'h6, 1'b0, 5, 1'b1);
    chk("stall_data", 32'(res_data), 32'hD);
    do_op(T_ADD, 4'h2, 4'h2, 1'b0, 0, 1'b0);
    chk("after_stall_data", 32'(res_data), 32'h4);

    // Boundary vectors
    for (int i = 0; i < 4; i++) do_op(tv_op[i], tv_a[i], tv_b[i], 1'b0, i % 2, 1'b0);

    // Counter wrap: 256 more operations
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      do_op(iv[1:0], iv[3:0], iv[7:4], iv[2], 0, 1'b0);
    end
    chk("wrap_count", 32'(op_count), 32'd8);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
